// File: rtl/pu_pipe.sv
// Two-stage (fetch / execute) processing unit with relative branches, HALT and a retired-instruction counter.
// Fetch is combinational through iaddr/idata; taken branches and HALT flush the one instruction behind them.
module pu_pipe #(
    parameter int WIDTH = 16,
    parameter int PCW   = 8,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [PCW-1:0]   iaddr,
    input  logic [15:0]      idata,
    output logic             we,
    output logic [2:0]       wad,
    output logic [WIDTH-1:0] wd,
    output logic             halted,
    output logic [CNTW-1:0]  icnt
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PCW-1:0]   r_pc;
    logic [PCW-1:0]   r_pc_ex;
    logic [15:0]      r_ir;
    logic             r_ir_vld;
    logic [WIDTH-1:0] r_rf [8];
    logic [CNTW-1:0]  r_icnt;

    logic             w_halted;
    logic             w_ex_vld;
    logic [3:0]       w_op;
    logic [2:0]       w_rd;
    logic [2:0]       w_ra;
    logic [2:0]       w_rb;
    logic [7:0]       w_imm;
    logic [WIDTH-1:0] w_ra_v;
    logic [WIDTH-1:0] w_rb_v;
    logic [WIDTH-1:0] w_rd_v;
    logic [WIDTH-1:0] w_sext_d;
    logic [PCW-1:0]   w_sext_pc;
    logic [PCW-1:0]   w_br_tgt;
    logic [WIDTH-1:0] w_res;
    logic             w_is_halt;
    logic             w_br_taken;
    logic             w_we;

    assign w_op      = r_ir[15:12];
    assign w_rd      = r_ir[11:9];
    assign w_ra      = r_ir[8:6];
    assign w_rb      = r_ir[5:3];
    assign w_imm     = r_ir[7:0];
    assign w_ra_v    = r_rf[w_ra];
    assign w_rb_v    = r_rf[w_rb];
    assign w_rd_v    = r_rf[w_rd];
    assign w_sext_d  = WIDTH'($signed(w_imm));
    assign w_sext_pc = PCW'($signed(w_imm));
    assign w_br_tgt  = r_pc_ex + w_sext_pc;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_RUN && w_is_halt) begin
            w_state_nxt = S_HALT;
        end
    end

    // FSM: outputs
    always_comb begin
        w_halted = (r_state == S_HALT);
        w_ex_vld = r_ir_vld && (r_state == S_RUN);
    end

    assign w_is_halt  = w_ex_vld && (w_op == 4'hF);
    assign w_br_taken = w_ex_vld && ((w_op == 4'hB) || ((w_op == 4'hA) && (w_rd_v == '0)));
    // Gating with rst keeps the in-flight instruction from writing during a reset cycle.
    assign w_we       = rst && w_ex_vld && (w_op >= 4'h1) && (w_op <= 4'h9);

    always_comb begin
        w_res = '0;
        case (w_op)
            4'h1:    w_res = w_ra_v + w_rb_v;
            4'h2:    w_res = w_ra_v - w_rb_v;
            4'h3:    w_res = w_ra_v & w_rb_v;
            4'h4:    w_res = w_ra_v | w_rb_v;
            4'h5:    w_res = w_ra_v ^ w_rb_v;
            4'h6:    w_res = w_ra_v << w_rb_v[SHW-1:0];
            4'h7:    w_res = w_ra_v >> w_rb_v[SHW-1:0];
            4'h8:    w_res = w_sext_d;
            4'h9:    w_res = w_rd_v + w_sext_d;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc     <= '0;
            r_pc_ex  <= '0;
            r_ir     <= '0;
            r_ir_vld <= 1'b0;
            r_icnt   <= '0;
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            if (w_we) begin
                r_rf[w_rd] <= w_res;
            end
            if (w_ex_vld) begin
                r_icnt <= r_icnt + CNTW'(1);
            end
            // HALT freezes the PC and leaves a bubble in IR for good.
            if (w_halted || w_is_halt) begin
                r_ir_vld <= 1'b0;
            end else if (w_br_taken) begin
                r_pc     <= w_br_tgt;
                r_ir_vld <= 1'b0;
            end else begin
                r_pc     <= r_pc + PCW'(1);
                r_pc_ex  <= r_pc;
                r_ir     <= idata;
                r_ir_vld <= 1'b1;
            end
        end
    end

    assign iaddr  = r_pc;
    assign we     = w_we;
    assign wad    = w_we ? w_rd : 3'd0;
    assign wd     = w_we ? w_res : '0;
    assign halted = w_halted;
    assign icnt   = r_icnt;

endmodule

// File: tb/tb_pu_pipe.sv
// Bench for pu_pipe: directed programs plus random programs checked cycle by cycle against an ISA-level model.
module tb_pu_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst4 = 1'b0;
    logic [15:0] imem [256];

    logic [7:0]  iaddr;
    logic [15:0] idata;
    logic        we;
    logic [2:0]  wad;
    logic [15:0] wd;
    logic        halted;
    logic [15:0] icnt;

    logic [3:0]  iaddr4;
    logic [15:0] idata4;
    logic        we4;
    logic [2:0]  wad4;
    logic [15:0] wd4;
    logic        halted4;
    logic [15:0] icnt4;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [2:0]  wad;
        logic [15:0] wd;
        logic [7:0]  iaddr;
        logic        halted;
        logic [15:0] icnt;
    } slot_t;

    slot_t exp_q[$];
    slot_t obs[200];

    always #5 clk = ~clk;

    assign idata  = imem[iaddr];
    assign idata4 = imem[{4'd0, iaddr4}];

    pu_pipe #(.WIDTH(16), .PCW(8), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .iaddr(iaddr), .idata(idata), .we(we),
        .wad(wad), .wd(wd), .halted(halted), .icnt(icnt)
    );

    pu_pipe #(.WIDTH(16), .PCW(4), .CNTW(16)) u_dut4 (
        .clk(clk), .rst(rst4), .iaddr(iaddr4), .idata(idata4), .we(we4),
        .wad(wad4), .wd(wd4), .halted(halted4), .icnt(icnt4)
    );

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 3'b000};
    endfunction

    function automatic logic [15:0] enci(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 256; i++) imem[i] = v;
    endtask

    // ISA-level model: executes the program sequentially and lays out one expected slot per cycle.
    task automatic build_expect(input int pcw, input int ncyc);
        logic [15:0] rf [8];
        logic [7:0]  pc, mask, tgt;
        logic [15:0] cnt, ins, a, b, d, res, sx;
        logic [3:0]  op;
        bit          hl, wr, tk;
        slot_t       s;
        mask = 8'((1 << pcw) - 1);
        for (int i = 0; i < 8; i++) rf[i] = 16'd0;
        pc = 8'd0; cnt = 16'd0; hl = 1'b0;
        exp_q.delete();
        s.we = 1'b0; s.wad = 3'd0; s.wd = 16'd0; s.iaddr = 8'd0; s.halted = 1'b0; s.icnt = 16'd0;
        exp_q.push_back(s);
        while (exp_q.size() < ncyc) begin
            if (hl) begin
                s.we = 1'b0; s.wad = 3'd0; s.wd = 16'd0; s.iaddr = pc; s.halted = 1'b1; s.icnt = cnt;
                exp_q.push_back(s);
            end else begin
                ins = imem[pc];
                op  = ins[15:12];
                a   = rf[ins[8:6]];
                b   = rf[ins[5:3]];
                d   = rf[ins[11:9]];
                sx  = {{8{ins[7]}}, ins[7:0]};
                wr  = (op >= 4'd1) && (op <= 4'd9);
                tk  = 1'b0;
                res = 16'd0;
                case (op)
                    4'd1:  res = a + b;
                    4'd2:  res = a - b;
                    4'd3:  res = a & b;
                    4'd4:  res = a | b;
                    4'd5:  res = a ^ b;
                    4'd6:  res = a << (b % 16);
                    4'd7:  res = a >> (b % 16);
                    4'd8:  res = sx;
                    4'd9:  res = d + sx;
                    4'd10: tk = (d == 16'd0);
                    4'd11: tk = 1'b1;
                    default: res = 16'd0;
                endcase
                tgt = (pc + sx[7:0]) & mask;
                s.we = wr; s.wad = wr ? ins[11:9] : 3'd0; s.wd = wr ? res : 16'd0;
                s.iaddr = (pc + 8'd1) & mask; s.halted = 1'b0; s.icnt = cnt;
                exp_q.push_back(s);
                if (wr) rf[ins[11:9]] = res;
                cnt = cnt + 16'd1;
                if (op == 4'hF) begin
                    hl = 1'b1;
                    pc = (pc + 8'd1) & mask;
                end else if (tk) begin
                    pc = tgt;
                    s.we = 1'b0; s.wad = 3'd0; s.wd = 16'd0; s.iaddr = pc; s.halted = 1'b0; s.icnt = cnt;
                    exp_q.push_back(s);
                end else begin
                    pc = (pc + 8'd1) & mask;
                end
            end
        end
    endtask

    task automatic do_reset(input bit use4);
        @(negedge clk);
        if (use4) rst4 = 1'b0; else rst = 1'b0;
        @(negedge clk);
        if (use4) rst4 = 1'b1; else rst = 1'b1;
        #1;
    endtask

    // Entered #1 after the negedge of slot 0; leaves #1 after the negedge of slot ncyc.
    task automatic run_program(input bit use4, input int ncyc, input string tag);
        slot_t o;
        for (int k = 0; k < ncyc; k++) begin
            if (use4) begin
                o.we = we4; o.wad = wad4; o.wd = wd4; o.iaddr = {4'd0, iaddr4}; o.halted = halted4; o.icnt = icnt4;
            end else begin
                o.we = we; o.wad = wad; o.wd = wd; o.iaddr = iaddr; o.halted = halted; o.icnt = icnt;
            end
            obs[k] = o;
            tests++;
            if ({o.we, o.wad, o.wd, o.iaddr, o.halted, o.icnt} !==
                {exp_q[k].we, exp_q[k].wad, exp_q[k].wd, exp_q[k].iaddr, exp_q[k].halted, exp_q[k].icnt}) begin
                fails++;
                $display("FAIL %s cycle %0d: got we=%0b wad=%0d wd=%h iaddr=%0d halted=%0b icnt=%0d, want we=%0b wad=%0d wd=%h iaddr=%0d halted=%0b icnt=%0d",
                         tag, k, o.we, o.wad, o.wd, o.iaddr, o.halted, o.icnt,
                         exp_q[k].we, exp_q[k].wad, exp_q[k].wd, exp_q[k].iaddr, exp_q[k].halted, exp_q[k].icnt);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        fill(16'h0000);
        @(negedge clk);
        #1;
        tests++;
        if (we !== 1'b0) begin
            fails++;
            $display("FAIL reset_we_low: got %0b want 0", we);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({iaddr, we, wad, wd, halted, icnt} !== {8'd0, 1'b0, 3'd0, 16'd0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL reset_state: got iaddr=%0d we=%0b wad=%0d wd=%h halted=%0b icnt=%0d want all 0",
                     iaddr, we, wad, wd, halted, icnt);
        end
    endtask

    task automatic test_alu;
        fill(16'h0000);
        imem[0] = enci(4'h8, 3'd1, 8'd5);
        imem[1] = enci(4'h8, 3'd2, 8'hFD);
        imem[2] = enc(4'h1, 3'd3, 3'd1, 3'd2);
        imem[3] = enc(4'h2, 3'd4, 3'd2, 3'd1);
        imem[4] = enc(4'h6, 3'd5, 3'd1, 3'd1);
        imem[5] = enci(4'h9, 3'd1, 8'h7F);
        imem[6] = 16'hF000;
        do_reset(1'b0);
        build_expect(8, 14);
        run_program(1'b0, 14, "alu");
        tests++;
        if ({obs[1].we, obs[1].wad, obs[2].we, obs[2].wad, obs[3].we, obs[3].wad} !==
            {1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3}) begin
            fails++;
            $display("FAIL alu_wad_seq: got %0d/%0d/%0d want 1/2/3", obs[1].wad, obs[2].wad, obs[3].wad);
        end
        tests++;
        if (obs[3].wd !== 16'd2 || obs[4].icnt !== 16'd3) begin
            fails++;
            $display("FAIL alu_add: got wd=%h icnt=%0d want 0002 and 3", obs[3].wd, obs[4].icnt);
        end
        tests++;
        if ({obs[4].wd, obs[5].wd, obs[6].wd} !== {16'hFFF8, 16'h00A0, 16'h0084}) begin
            fails++;
            $display("FAIL alu_sub_shl_addi: got %h %h %h want fff8 00a0 0084", obs[4].wd, obs[5].wd, obs[6].wd);
        end
    endtask

    task automatic test_branch;
        fill(16'hF000);
        imem[0]  = enci(4'h8, 3'd1, 8'd1);
        imem[1]  = 16'h0000;
        imem[2]  = 16'h0000;
        imem[3]  = 16'h0000;
        imem[4]  = enci(4'hA, 3'd0, 8'd3);
        imem[5]  = enci(4'h8, 3'd6, 8'd9);
        imem[6]  = enci(4'h8, 3'd6, 8'h11);
        imem[7]  = enci(4'h8, 3'd7, 8'd2);
        imem[8]  = enci(4'hA, 3'd1, 8'd5);
        imem[9]  = enci(4'h8, 3'd2, 8'd3);
        imem[10] = 16'hF000;
        do_reset(1'b0);
        build_expect(8, 16);
        run_program(1'b0, 16, "branch");
        tests++;
        if ({obs[4].iaddr, obs[5].iaddr, obs[6].iaddr} !== {8'd4, 8'd5, 8'd7} || obs[6].we !== 1'b0) begin
            fails++;
            $display("FAIL beqz_taken: got iaddr %0d,%0d,%0d we=%0b want 4,5,7 we=0",
                     obs[4].iaddr, obs[5].iaddr, obs[6].iaddr, obs[6].we);
        end
        tests++;
        if ({obs[9].we, obs[9].wad, obs[9].iaddr} !== {1'b1, 3'd2, 8'd10}) begin
            fails++;
            $display("FAIL beqz_fallthrough: got we=%0b wad=%0d iaddr=%0d want 1 2 10", obs[9].we, obs[9].wad, obs[9].iaddr);
        end
        tests++;
        if (obs[15].icnt !== 16'd9) begin
            fails++;
            $display("FAIL branch_icnt: got %0d want 9", obs[15].icnt);
        end
    endtask

    task automatic test_halt;
        fill(enci(4'h8, 3'd7, 8'd1));
        for (int i = 0; i < 6; i++) imem[i] = enci(4'h8, 3'(i), 8'(i + 1));
        imem[6] = 16'hF000;
        do_reset(1'b0);
        build_expect(8, 24);
        run_program(1'b0, 24, "halt");
        for (int k = 8; k < 24; k += 5) begin
            tests++;
            if ({obs[k].halted, obs[k].iaddr, obs[k].icnt, obs[k].we} !== {1'b1, 8'd7, 16'd7, 1'b0}) begin
                fails++;
                $display("FAIL halt_frozen cycle %0d: got halted=%0b iaddr=%0d icnt=%0d we=%0b want 1 7 7 0",
                         k, obs[k].halted, obs[k].iaddr, obs[k].icnt, obs[k].we);
            end
        end
    endtask

    task automatic test_pc_wrap;
        fill(16'h0000);
        imem[0] = enci(4'hB, 3'd0, 8'hFF);
        do_reset(1'b1);
        build_expect(4, 30);
        run_program(1'b1, 30, "pc_wrap");
        tests++;
        if ({obs[2].iaddr, obs[3].iaddr, obs[2].we} !== {8'd15, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL pc_wrap: got iaddr %0d,%0d want 15,0", obs[2].iaddr, obs[3].iaddr);
        end
        rst4 = 1'b0;
    endtask

    task automatic test_reset_mid;
        fill(16'h0000);
        imem[0] = enc(4'h1, 3'd4, 3'd1, 3'd2);
        imem[1] = enci(4'h8, 3'd1, 8'd3);
        imem[2] = enci(4'h8, 3'd2, 8'd4);
        imem[3] = enci(4'hB, 3'd0, 8'd2);
        imem[4] = enci(4'h8, 3'd6, 8'd1);
        imem[5] = enc(4'h1, 3'd4, 3'd1, 3'd2);
        imem[6] = enci(4'hA, 3'd0, 8'd0);
        do_reset(1'b0);
        build_expect(8, 5);
        run_program(1'b0, 5, "pre_reset");
        rst = 1'b0;
        #1;
        tests++;
        if (we !== 1'b0) begin
            fails++;
            $display("FAIL midreset_we: got %0b want 0", we);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({iaddr, we, wad, wd, halted, icnt} !== {8'd0, 1'b0, 3'd0, 16'd0, 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL midreset_state: got iaddr=%0d we=%0b wad=%0d wd=%h halted=%0b icnt=%0d want all 0",
                     iaddr, we, wad, wd, halted, icnt);
        end
        build_expect(8, 24);
        run_program(1'b0, 24, "post_reset");
        tests++;
        if ({obs[1].we, obs[1].wad, obs[1].wd} !== {1'b1, 3'd4, 16'd0}) begin
            fails++;
            $display("FAIL midreset_regs_cleared: got wad=%0d wd=%h want 4 0000", obs[1].wad, obs[1].wd);
        end
    endtask

    task automatic test_random;
        logic [15:0] ins;
        for (int it = 0; it < 6; it++) begin
            fill(16'hF000);
            for (int a = 0; a < 40; a++) begin
                ins = 16'($urandom);
                ins[15:12] = 4'($urandom_range(0, 14));
                if (ins[15:12] == 4'hA || ins[15:12] == 4'hB) ins[7:0] = 8'($urandom_range(1, 4));
                imem[a] = ins;
            end
            do_reset(1'b0);
            build_expect(8, 70);
            run_program(1'b0, 70, "random");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_halt();
        test_pc_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
